// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared forwarding encodings, stall FSM states and register-address width
package pipeline_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic {RUN, STALL} stall_state_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: EX-operand forwarding select for one source register (MEM beats WB, $0 never forwards)
module fwd_select
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_write_addr,
    output logic [1:0]        sel
);
    always_comb
        sel = (mem_regwrite && mem_write_addr != '0 && mem_write_addr == src) ? FWD_MEM :
              (wb_regwrite && wb_write_addr != '0 && wb_write_addr == src)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall FSM, branch flush, EX forwarding selects and saturating event counters
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic [REG_AW-1:0] wb_write_addr,
    input  logic              mem_pcsrc,
    input  logic              cnt_clear,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    // STALL covers the cycles after the detection cycle, so it counts down from N-2
    localparam logic [1:0] SCNT_INIT = LOAD_STALL_CYCLES > 1 ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    stall_state_t state, next_state;
    logic [1:0] scnt, next_scnt;
    logic hz, stall;
    logic [1:0] sel_a, sel_b;
    fwd_select u_fwd_a (
        .src(ex_rs), .mem_regwrite(mem_regwrite), .mem_write_addr(mem_write_addr),
        .wb_regwrite(wb_regwrite), .wb_write_addr(wb_write_addr), .sel(sel_a)
    );
    fwd_select u_fwd_b (
        .src(ex_rt), .mem_regwrite(mem_regwrite), .mem_write_addr(mem_write_addr),
        .wb_regwrite(wb_regwrite), .wb_write_addr(wb_write_addr), .sel(sel_b)
    );
    always_comb begin
        hz = ex_memread && ex_rt != '0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        // a taken branch overrides any stall; RST low forces every control inactive
        stall = RST && !mem_pcsrc && (state == STALL || hz);
        next_state = state;
        next_scnt = scnt;
        if (mem_pcsrc)
            next_state = RUN;
        else if (state == STALL) begin
            if (scnt == '0) next_state = RUN;
            else next_scnt = scnt - 2'd1;
        end else if (hz && LOAD_STALL_CYCLES > 1) begin
            next_state = STALL;
            next_scnt = SCNT_INIT;
        end
        pc_write = RST && !stall;
        if_id_write = RST && !stall;
        id_ex_bubble = stall;
        if_id_flush = RST && mem_pcsrc;
        id_ex_flush = RST && mem_pcsrc;
        ex_mem_flush = RST && mem_pcsrc;
        fwd_a = RST ? sel_a : FWD_RF;
        fwd_b = RST ? sel_b : FWD_RF;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RUN;
            scnt <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= next_state;
            scnt <= next_scnt;
            if (cnt_clear) begin
                stall_count <= '0;
                flush_count <= '0;
            end else begin
                if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
                if (mem_pcsrc && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and stalls IF/ID for a configurable number of cycles. It flushes the three younger stages when a branch resolves taken in MEM, and generates the EX-stage forwarding selects. It also keeps saturating stall and flush event counters. It sits beside the stage registers and drives their write-enable, bubble and flush controls; the ID/EX register carries Rs for this block.

## Interface
- LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (legal 1–3; values >1 cover slow data memory).
- CNT_W, 16, width of the event counters.

- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_memread  in  1  EX instruction is a load.
- ex_rs, ex_rt  in  5 each  EX source registers; ex_rt is also the load destination.
- mem_regwrite, wb_regwrite  in  1 each  stage writes the register file.
- mem_write_addr, wb_write_addr  in  5 each  destination register of MEM / WB.
- mem_pcsrc  in  1  branch in MEM is taken.
- cnt_clear  in  1  synchronous clear of both counters.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  zero all ID/EX control fields on this edge.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the stage register on this edge.
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 01 = WB, 10 = MEM.
- stall_count, flush_count  out  CNT_W each  event counters.

## Operation
- **Load-use hazard (hz):** ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- **FSM states:**
  - RUN: hz && !mem_pcsrc → drive stall outputs this cycle. If LOAD_STALL_CYCLES > 1, go to STALL with scnt = LOAD_STALL_CYCLES-2; otherwise stay in RUN.
  - STALL: drive stall outputs. When scnt == 0 go to RUN; otherwise decrement scnt.
- **Stall outputs:** pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Outside a stall: pc_write = 1, if_id_write = 1, id_ex_bubble = 0.
- **Flush:** mem_pcsrc = 1 asserts all three flushes in the same cycle, combinationally.
  - Flush has priority: stall outputs are deasserted and pc_write = 1 so the branch target loads.
  - Flush in STALL aborts the stall; next state is RUN.
- **Forwarding (fwd_a, with ex_rs):**
  - 10 if mem_regwrite && mem_write_addr != 0 && mem_write_addr == ex_rs.
  - else 01 if wb_regwrite && wb_write_addr != 0 && wb_write_addr == ex_rs.
  - else 00.
  - MEM beats WB when both match. fwd_b is identical using ex_rt.
- **Counters:**
  - stall_count +1 on every cycle with stall outputs asserted.
  - flush_count +1 on every cycle with mem_pcsrc.
  - Both saturate at all-ones and do not wrap.
  - cnt_clear wins over increment in the same cycle.
- Register $0 never triggers a hazard or forwarding.

## Timing
- Stall, flush and forwarding outputs are combinational, valid in the same cycle as their inputs, and take effect on the next CLK edge.
- Hazard detected at cycle t holds PC and IF/ID for cycles t … t+LOAD_STALL_CYCLES-1. The ID instruction re-enters decode at t+LOAD_STALL_CYCLES.
- A hazard recognised in STALL is not re-detected: the load has already left EX.
- Branch penalty: 3 cycles, with no FSM involvement.
- **Reset (RST low), asynchronous:**
  - State = RUN, scnt = 0, counters = 0.
  - While held: pc_write = 0, if_id_write = 0, id_ex_bubble = 0, all flushes = 0, fwd_a = fwd_b = 00.
- Reset release is recognised on the first CLK edge after deassertion.
- Reset mid-stall discards the stall.

## Structure
- Package pipeline_ctrl_pkg holds:
  - Forwarding encodings FWD_RF / FWD_WB / FWD_MEM (2-bit).
  - FSM state enum {RUN, STALL}.
  - Register-address width constant (5).
- Sub-module fwd_select (comparator and priority logic for one operand), instantiated twice for A and B.
- Stall FSM and counters live in the top module.

## Test plan
- **Load-use, N=1:** ex_memread=1, ex_rt=8, id_rs=8 → one cycle of pc_write=0 / id_ex_bubble=1, then pc_write=1; stall_count=1.
- **N=3, hazard via rt:** ex_rt=9, id_rt=9, id_uses_rt=1 → stall for exactly 3 cycles; stall_count=3. Same registers with id_uses_rt=0 → no stall.
- **Flush vs stall:** mem_pcsrc=1 during STALL (N=3, second cycle) → all flushes=1, pc_write=1 that cycle, next state RUN, flush_count=1.
- **Forwarding priority:** mem_write_addr = wb_write_addr = ex_rs = 5, both regwrite → fwd_a=10. MEM regwrite=0 → fwd_a=01. Addr 0 → fwd_a=00.
- **Saturation and clear (CNT_W=4):** 20 flush cycles → flush_count=15. cnt_clear together with mem_pcsrc → 0.
- **Async reset mid-stall:** RST low between clock edges in STALL → counters 0 immediately, pc_write=0. After release → RUN with no residual stall.
